// File: rtl/ripple_counter_4bit_pkg.sv
// ----------------------------------------------------------------------------
// ripple_counter_4bit_pkg
// Purpose : shared constants for the 4-bit toggle-chain down counter.
// Contents: RC_WIDTH - default number of counter stages / output width.
// ----------------------------------------------------------------------------
package ripple_counter_4bit_pkg;

    localparam int unsigned RC_WIDTH = 4;

endpackage : ripple_counter_4bit_pkg

// File: rtl/ripple_counter_4bit_if.sv
// ----------------------------------------------------------------------------
// ripple_counter_4bit_if
// Purpose : carries the counter's display/probe output bus.
// Signals : out [WIDTH-1:0] - inverted counter state (counts down).
// Modports: master - counter side (drives out)
//           slave  - consumer side (reads out)
// ----------------------------------------------------------------------------
interface ripple_counter_4bit_if
    import ripple_counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = RC_WIDTH
);

    logic [WIDTH-1:0] out;

    modport master (output out);
    modport slave  (input  out);

endinterface : ripple_counter_4bit_if

// File: rtl/ripple_counter_4bit_t_stage.sv
// ----------------------------------------------------------------------------
// t_stage
// Purpose : one toggle-flop stage of the counter, clocked by the common clk.
// Ports   : clk  in  - rising-edge clock
//           rstn in  - synchronous active-high reset, loads RESET_VAL
//           t    in  - toggle enable; q inverts on the edge when t==1
//           q    out - stage state
// ----------------------------------------------------------------------------
module t_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);

    logic r_q;

    // Reset wins over toggling.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule : t_stage

// File: rtl/ripple_counter_4bit.sv
// ----------------------------------------------------------------------------
// ripple_counter_4bit
// Purpose : binary down counter built as a toggle-stage chain. Internal state
//           q counts up; the bus output is ~q, so it decrements by one per
//           non-reset edge (1111, 1110, ..., 0000, 1111, ...).
// Ports   : clk   in  - single rising-edge clock for every stage
//           rstn  in  - synchronous active-high reset (q <= 0, out = 1111)
//           o_bus     - ripple_counter_4bit_if.master, o_bus.out = ~q
// ----------------------------------------------------------------------------
module ripple_counter_4bit
    import ripple_counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = RC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    ripple_counter_4bit_if.master o_bus
);

    localparam logic [WIDTH-1:0] RESET_Q = '0;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t;

    // Stage 0 always toggles; stage i toggles only when every lower stage is 1,
    // i.e. when all lower stages wrap 1->0 on this edge.
    assign w_t[0] = 1'b1;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        if (i > 0) begin : g_chain
            assign w_t[i] = w_t[i-1] & w_q[i-1];
        end

        t_stage #(
            .RESET_VAL (RESET_Q[i])
        ) u_t_stage (
            .clk  (clk),
            .rstn (rstn),
            .t    (w_t[i]),
            .q    (w_q[i])
        );
    end

    // All stages share one edge, so the inverted state changes cleanly.
    assign o_bus.out = ~w_q;

endmodule : ripple_counter_4bit

// File: tb/tb_ripple_counter_4bit.sv
// ----------------------------------------------------------------------------
// tb_ripple_counter_4bit
// Purpose : self-checking bench for ripple_counter_4bit. A table of directed
//           {rstn, expected out} steps, hand-written reset/wrap sequences, and
//           a randomized reset pattern checked against an edge-count model.
// ----------------------------------------------------------------------------
module tb_ripple_counter_4bit;

    typedef struct {
        logic       rstn;
        logic [3:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rstn;

    int vectors;
    int miscompares;
    int model_edges;   // edges since the last reset edge

    vec_t tbl[$];

    ripple_counter_4bit_if #(.WIDTH(4)) u_if ();

    ripple_counter_4bit #(
        .WIDTH (4)
    ) u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .o_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: out = F - (edges since reset mod 16).
    function automatic logic [3:0] model_out();
        return 4'(15 - (model_edges % 16));
    endfunction

    task automatic add(input logic r, input logic [3:0] e, input string n);
        vec_t v;
        v.rstn = r;
        v.exp  = e;
        v.name = n;
        tbl.push_back(v);
    endtask

    task automatic check(input string n, input logic [3:0] exp);
        vectors++;
        if (u_if.out !== exp) begin
            miscompares++;
            $display("FAIL %s: out=%b expected %b (t=%0t)", n, u_if.out, exp, $time);
        end
    endtask

    // Drive rstn away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic r);
        @(negedge clk);
        rstn = r;
        @(posedge clk);
        if (r) model_edges = 0;
        else   model_edges++;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_edges = 0;
        rstn        = 1'b1;

        // Reset twice, 15 decrements, wrap, count to 1010, reset, resume.
        add(1'b1, 4'hF, "reset_edge1");
        add(1'b1, 4'hF, "reset_edge2");
        for (int i = 1; i <= 15; i++) add(1'b0, 4'(15 - i), "count_down");
        add(1'b0, 4'hF, "wrap_to_1111");
        for (int i = 1; i <= 5; i++) add(1'b0, 4'(15 - i), "count_to_1010");
        add(1'b1, 4'hF, "reset_mid_count");
        add(1'b0, 4'hE, "resume_after_reset");

        foreach (tbl[k]) begin
            step(tbl[k].rstn);
            check(tbl[k].name, tbl[k].exp);
        end

        // Count a few edges, then hold reset 5 edges: no decrement allowed.
        for (int i = 0; i < 3; i++) step(1'b0);
        check("pre_hold_count", 4'hB);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("reset_hold", 4'hF);
        end

        // Full period from reset: 16 edges must land back on 1111 with 0000 just before.
        for (int i = 0; i < 15; i++) step(1'b0);
        check("period_last", 4'h0);
        step(1'b0);
        check("period_wrap", 4'hF);

        // Clean 40-edge run from release, then randomized resets.
        step(1'b1);
        check("model_reset", model_out());
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            check("model_run", model_out());
        end
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
            check("model_random", model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ripple_counter_4bit
